mem_responder: RTL and testbench

//  Word-organised memory target answering load/store/fetch requests from the

---
 rtl/mem_responder_if.sv | 31 +++
 rtl/mem_responder.sv | 105 ++++++++++
 tb/tb_mem_responder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between the multicycle control FSM and mem_responder.
// MEM_BYTE_MASK_EN adds the req_be byte-enable lane.
interface mem_responder_if #(
  parameter int N      = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [N-1:0]      req_wdata;
`ifdef MEM_BYTE_MASK_EN
  logic [N/8-1:0]    req_be;
`endif
  logic              resp_valid;
  logic              resp_ready;
  logic [N-1:0]      resp_rdata;
  logic              resp_err;

`ifdef MEM_BYTE_MASK_EN
  modport master (output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
                  input  req_ready, resp_valid, resp_rdata, resp_err);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
                  output req_ready, resp_valid, resp_rdata, resp_err);
`else
  modport master (output req_valid, req_we, req_addr, req_wdata, resp_ready,
                  input  req_ready, resp_valid, resp_rdata, resp_err);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata, resp_ready,
                  output req_ready, resp_valid, resp_rdata, resp_err);
`endif
endinterface

// File: rtl/mem_responder.sv
// Word memory target with LATENCY wait states and valid/ready request/response handshake.
// Optional MEM_BYTE_MASK_EN: per-byte store enables latched with the request.
module mem_responder #(
  parameter int N       = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int NB    = N / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [N-1:0]      lat_wdata;
  logic [NB-1:0]     wr_mask;
  logic [N-1:0]      mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              addr_err;
  logic              commit;

`ifdef MEM_BYTE_MASK_EN
  logic [NB-1:0]     lat_be;
  assign wr_mask = lat_be;
`else
  assign wr_mask = '1;
`endif

  assign idx      = lat_addr[IDX_W+1:2];
  assign addr_err = (lat_addr[1:0] != 2'b00) || ((lat_addr >> (IDX_W + 2)) != '0);
  assign commit   = rst && (state == WAIT) && (wait_cnt == 4'd0);

  // Array is deliberately outside the reset domain; contents survive rst.
  always_ff @(posedge clk) begin
    if (commit && lat_we && !addr_err) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_mask[b]) mem[idx][b*8 +: 8] <= lat_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      wait_cnt       <= 4'd0;
      bus.req_ready  <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // req_ready is raised one cycle after entering IDLE, so no accept in the release cycle.
          if (!bus.req_ready) begin
            bus.req_ready <= 1'b1;
          end else if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            lat_we        <= bus.req_we;
            lat_addr      <= bus.req_addr;
            lat_wdata     <= bus.req_wdata;
`ifdef MEM_BYTE_MASK_EN
            lat_be        <= bus.req_be;
`endif
            wait_cnt      <= 4'(LATENCY - 1);
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            // Read samples the pre-commit array; a store in this same slot returns 0 anyway.
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= addr_err;
            bus.resp_rdata <= (addr_err || lat_we) ? '0 : mem[idx];
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state          <= IDLE;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          wait_cnt       <= 4'd0;
          bus.req_ready  <= 1'b0;
          bus.resp_valid <= 1'b0;
          bus.resp_rdata <= '0;
          bus.resp_err   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=2 main instance plus a LATENCY=1 instance.
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mem_responder_if #(.N(32), .ADDR_W(32)) bus  ();
  mem_responder_if #(.N(32), .ADDR_W(32)) bus1 ();

  mem_responder #(.N(32), .ADDR_W(32), .DEPTH(256), .LATENCY(2)) dut  (.clk(clk), .rst(rst), .bus(bus));
  mem_responder #(.N(32), .ADDR_W(32), .DEPTH(256), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err);
    int n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.resp_valid && lat < 20) begin @(negedge clk); lat++; end
    rdata = bus.resp_rdata; err = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  task automatic do_req1(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err);
    int n = 0;
    while (!bus1.req_ready && n < 20) begin @(negedge clk); n++; end
    bus1.req_valid = 1'b1; bus1.req_we = we; bus1.req_addr = addr; bus1.req_wdata = wdata;
    @(negedge clk);
    bus1.req_valid = 1'b0;
    lat = 0;
    while (!bus1.resp_valid && lat < 20) begin @(negedge clk); lat++; end
    rdata = bus1.resp_rdata; err = bus1.resp_err;
    bus1.resp_ready = 1'b1;
    @(negedge clk);
    bus1.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata} !== 35'd0) begin
        bad++;
        $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b rdata=%h want all 0",
                 bus.req_ready, bus.resp_valid, bus.resp_err, bus.resp_rdata);
      end
    end
    bus.req_valid = 1'b0;
    rst = 1'b1;
    total++;
    if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL reset_release_same: got %b want 0", bus.req_ready); end
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after: got %b want 1", bus.req_ready); end
    total++;
    if (bus1.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_lat1: got %b want 1", bus1.req_ready); end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 32'h10, 32'hDEADBEEF, lat, rd, er);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL store_latency: got %0d want 2", lat); end
    total++;
    if ({er, rd} !== 33'd0) begin bad++; $display("FAIL store_resp: got err=%b rdata=%h want 0/0", er, rd); end
    do_req(1'b0, 32'h10, 32'h0, lat, rd, er);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL load_latency: got %0d want 2", lat); end
    total++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL load_data: got err=%b rdata=%h want 0/deadbeef", er, rd); end
  endtask

  task automatic test_errors();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b0, 32'h13, 32'h0, lat, rd, er);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL misaligned_load: got err=%b rdata=%h want 1/0", er, rd); end
    do_req(1'b0, 32'h400, 32'h0, lat, rd, er);
    total++;
    if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL range_load: got err=%b rdata=%h want 1/0", er, rd); end
    do_req(1'b1, 32'h11, 32'h55555555, lat, rd, er);
    total++;
    if (er !== 1'b1) begin bad++; $display("FAIL misaligned_store_err: got %b want 1", er); end
    do_req(1'b1, 32'h410, 32'h66666666, lat, rd, er);
    total++;
    if (er !== 1'b1) begin bad++; $display("FAIL range_store_err: got %b want 1", er); end
    do_req(1'b0, 32'h10, 32'h0, lat, rd, er);
    total++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL mem_unchanged: got err=%b rdata=%h want 0/deadbeef", er, rd); end
    do_req(1'b1, 32'h3FC, 32'h0BADF00D, lat, rd, er);
    do_req(1'b0, 32'h3FC, 32'h0, lat, rd, er);
    total++;
    if (rd !== 32'h0BADF00D || er !== 1'b0) begin bad++; $display("FAIL last_word: got err=%b rdata=%h want 0/0badf00d", er, rd); end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] rd; logic er; int n;
    do_req(1'b1, 32'h40, 32'h01020304, lat, rd, er);
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h10;
    @(negedge clk);
    n = 0;
    while (!bus.resp_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h40 + 32'(i * 4) - 32'(i * 4);
      bus.req_wdata = 32'hA5A5A5A5;
      @(negedge clk);
      total++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hDEADBEEF || bus.resp_err !== 1'b0 || bus.req_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_cycle%0d: got vld=%b rdata=%h err=%b rdy=%b want 1/deadbeef/0/0",
                 i, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready);
      end
    end
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    total++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      bad++; $display("FAIL release_cycle: got vld=%b rdy=%b want 0/0", bus.resp_valid, bus.req_ready);
    end
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_release: got %b want 1", bus.req_ready); end
    do_req(1'b0, 32'h40, 32'h0, lat, rd, er);
    total++;
    if (rd !== 32'h01020304 || lat !== 2) begin bad++; $display("FAIL ignored_store: got rdata=%h lat=%0d want 01020304/2", rd, lat); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er; int n;
    do_req(1'b1, 32'h20, 32'h11112222, lat, rd, er);
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h20; bus.req_wdata = 32'h12345678;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      bad++; $display("FAIL midreset_outputs: got vld=%b rdy=%b want 0/0", bus.resp_valid, bus.req_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL midreset_recover: got rdy=%b vld=%b want 1/0", bus.req_ready, bus.resp_valid);
    end
    do_req(1'b0, 32'h20, 32'h0, lat, rd, er);
    total++;
    if (rd !== 32'h11112222 || er !== 1'b0) begin bad++; $display("FAIL store_dropped: got rdata=%h err=%b want 11112222/0", rd, er); end
  endtask

  task automatic test_latency1();
    int lat; logic [31:0] rd; logic er;
    do_req1(1'b1, 32'h8, 32'hCAFEF00D, lat, rd, er);
    total++;
    if (lat !== 1) begin bad++; $display("FAIL lat1_store: got %0d want 1", lat); end
    do_req1(1'b0, 32'h8, 32'h0, lat, rd, er);
    total++;
    if (lat !== 1 || rd !== 32'hCAFEF00D || er !== 1'b0) begin
      bad++; $display("FAIL lat1_load: got lat=%0d rdata=%h err=%b want 1/cafef00d/0", lat, rd, er);
    end
  endtask

`ifdef MEM_BYTE_MASK_EN
  task automatic test_byte_mask();
    int lat; logic [31:0] rd; logic er;
    bus.req_be = 4'hF;
    do_req(1'b1, 32'h0, 32'hFFFFFFFF, lat, rd, er);
    bus.req_be = 4'b0101;
    do_req(1'b1, 32'h0, 32'h00000000, lat, rd, er);
    bus.req_be = 4'b0000;
    do_req(1'b0, 32'h0, 32'h0, lat, rd, er);
    total++;
    if (rd !== 32'hFF00FF00) begin bad++; $display("FAIL byte_mask: got %h want ff00ff00", rd); end
    do_req(1'b1, 32'h0, 32'h12345678, lat, rd, er);
    total++;
    if (er !== 1'b0) begin bad++; $display("FAIL be_zero_err: got %b want 0", er); end
    do_req(1'b0, 32'h0, 32'h0, lat, rd, er);
    total++;
    if (rd !== 32'hFF00FF00) begin bad++; $display("FAIL be_zero_noop: got %h want ff00ff00", rd); end
    bus.req_be = 4'hF;
  endtask
`endif

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0; bus1.req_wdata = '0; bus1.resp_ready = 1'b0;
`ifdef MEM_BYTE_MASK_EN
    bus.req_be = 4'hF; bus1.req_be = 4'hF;
`endif
    test_reset();
    test_store_load();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_latency1();
`ifdef MEM_BYTE_MASK_EN
    test_byte_mask();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
